// File: rtl/in_feature_loader_1_pkg.sv
// Shared definitions for the layer-1 in-feature loader: FSM encoding and
// default sizing constants.
package in_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } loader_state_t;

  localparam int FRAME_COUNT_WIDTH   = 16;
  localparam int DEFAULT_FRAME_WORDS = 1024;

endpackage

// File: rtl/in_feature_loader_1_if.sv
// Valid/ready stream carrying one in-feature word per RAM bank per beat.
interface in_feature_loader_1_if #(
  parameter int WIDTH = 48
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/in_feature_loader_1_rise_detect.sv
// Registered rising-edge detector; a synchronous clear forces the history
// high so a level that is already asserted cannot report a new rise.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic rise
);

  logic prev_r;

  // Previous-sample register, preloaded high while cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else if (clear) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= d;
    end
  end

  assign rise = d & ~prev_r;

endmodule

// File: rtl/in_feature_loader_1.sv
// Loads one frame from a stream into the in-feature RAM banks, then lends
// the RAM read ports to layer 1 until its pool_done rises.
module in_feature_loader_1
  import in_loader_pkg::*;
#(
  parameter int DATA_WIDTH            = 16,
  parameter int INPUT_NUM_MEM         = 3,
  parameter int IN_FEATURE_ADDR_WIDTH = 10,
  parameter int FRAME_WORDS           = DEFAULT_FRAME_WORDS
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  in_feature_loader_1_if.slave                   s,
  input  logic [IN_FEATURE_ADDR_WIDTH-1:0]       l1_addra,
  input  logic [IN_FEATURE_ADDR_WIDTH-1:0]       l1_addrb,
  input  logic                                   l1_rden_a,
  input  logic                                   l1_rden_b,
  input  logic                                   l1_wren_a,
  input  logic                                   l1_wren_b,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0]       ram_addr_a,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0]       ram_addr_b,
  output logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]    ram_data_a,
  output logic                                   ram_rden_a,
  output logic                                   ram_rden_b,
  output logic                                   ram_wren_a,
  output logic                                   ram_wren_b,
  output logic                                   l1_enable,
  input  logic                                   pool_done,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0]           frame_count
);

  localparam int AW     = IN_FEATURE_ADDR_WIDTH;
  localparam int WCNT_W = IN_FEATURE_ADDR_WIDTH + 1;
  localparam int BEAT_W = DATA_WIDTH * INPUT_NUM_MEM;

  // One extra counter bit lets a full 2^AW frame finish without wrapping.
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [WCNT_W-1:0] FULL_COUNT = WCNT_W'(FRAME_WORDS);

  loader_state_t                 state_r;
  logic [WCNT_W-1:0]             wcnt_r;
  logic [AW-1:0]                 ram_addr_a_r;
  logic [BEAT_W-1:0]             ram_data_a_r;
  logic                          ram_wren_a_r;
  logic                          s_ready_r;
  logic                          l1_enable_r;
  logic                          busy_r;
  logic                          frame_done_r;
  logic [FRAME_COUNT_WIDTH-1:0]  frame_count_r;
  logic                          pool_rise_s;
  logic                          rise_clear_s;
  logic                          accept_s;
  logic                          unused_l1_wren_s;

  assign accept_s     = s.s_valid & s_ready_r;
  assign rise_clear_s = (state_r != ST_RUN);

  // Layer 1 write requests are never honoured; keep them visibly consumed.
  assign unused_l1_wren_s = l1_wren_a ^ l1_wren_b;

  rise_detect u_pool_rise (
    .clock (clock),
    .reset (reset),
    .clear (rise_clear_s),
    .d     (pool_done),
    .rise  (pool_rise_s)
  );

  // Loader FSM with all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wcnt_r        <= '0;
      ram_addr_a_r  <= '0;
      ram_data_a_r  <= '0;
      ram_wren_a_r  <= 1'b0;
      s_ready_r     <= 1'b0;
      l1_enable_r   <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_count_r <= '0;
    end else begin
      ram_wren_a_r <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_LOAD;
            wcnt_r    <= '0;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            ram_addr_a_r <= wcnt_r[AW-1:0];
            ram_data_a_r <= s.s_data;
            ram_wren_a_r <= 1'b1;
            wcnt_r       <= wcnt_r + WCNT_W'(1);
            if (wcnt_r == LAST_WORD) begin
              s_ready_r <= 1'b0;
            end
          end else if (wcnt_r == FULL_COUNT) begin
            // Last write strobe is on the bus this cycle; hand over next.
            state_r     <= ST_RUN;
            l1_enable_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pool_rise_s) begin
            state_r       <= ST_IDLE;
            l1_enable_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b1;
            frame_count_r <= frame_count_r + FRAME_COUNT_WIDTH'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          s_ready_r   <= 1'b0;
          l1_enable_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: layer 1 owns the read ports in RUN, loader owns port A otherwise.
  always_comb begin
    ram_addr_a = ram_addr_a_r;
    ram_addr_b = '0;
    ram_rden_a = 1'b0;
    ram_rden_b = 1'b0;
    ram_wren_a = ram_wren_a_r;
    ram_wren_b = 1'b0;
    if (state_r == ST_RUN) begin
      ram_addr_a = l1_addra;
      ram_addr_b = l1_addrb;
      ram_rden_a = l1_rden_a;
      ram_rden_b = l1_rden_b;
      ram_wren_a = 1'b0;
      ram_wren_b = 1'b0;
    end else begin
      ram_addr_a = ram_addr_a_r;
      ram_wren_a = ram_wren_a_r;
    end
  end

  assign ram_data_a  = ram_data_a_r;
  assign s.s_ready   = s_ready_r;
  assign l1_enable   = l1_enable_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign frame_count = frame_count_r;

endmodule

// File: doc/in_feature_loader_1.md
# in_feature_loader_1

Upstream stage of layer 1. It accepts one input frame as a valid/ready stream and writes it into the INPUT_NUM_MEM in-feature RAM banks. It then hands the RAM read ports to layer 1, asserts layer 1's enable, and waits for pool_done. After that it reports frame completion and can accept the next frame. Its RAM port outputs drive the in-feature RAMs whose q_a/q_b buses feed layer 1's in_feature_q_a_all and in_feature_q_b_all.

## Interface
Parameters (defaults come from the `param_1.vh` macros):
- DATA_WIDTH, 16, width of one feature word.
- INPUT_NUM_MEM, 3, number of in-feature RAM banks; one stream beat carries one word per bank.
- IN_FEATURE_ADDR_WIDTH, 10, RAM address width.
- FRAME_WORDS, 1024, beats per frame; range 1..2^IN_FEATURE_ADDR_WIDTH.

Ports:
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load and run one frame.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  loader accepts a beat.
- s_data  in  DATA_WIDTH*INPUT_NUM_MEM  beat payload; slice k goes to bank k.
- l1_addra, l1_addrb  in  IN_FEATURE_ADDR_WIDTH each  layer 1 read addresses.
- l1_rden_a, l1_rden_b, l1_wren_a, l1_wren_b  in  1 each  layer 1 port strobes.
- ram_addr_a, ram_addr_b  out  IN_FEATURE_ADDR_WIDTH each  addresses to all banks.
- ram_data_a  out  DATA_WIDTH*INPUT_NUM_MEM  write data, one slice per bank.
- ram_rden_a, ram_rden_b, ram_wren_a, ram_wren_b  out  1 each  RAM port strobes.
- l1_enable  out  1  enable to layer 1.
- pool_done  in  1  layer 1 completion.
- busy  out  1  high in LOAD and RUN.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_count  out  16  number of completed frames; wraps.

## Operation
States:
- IDLE
  - s_ready=0 and l1_enable=0; all RAM strobes are 0.
  - start=1 moves to LOAD and clears the word counter wcnt.
- LOAD
  - s_ready=1.
  - A beat is accepted when s_valid&&s_ready. On acceptance, register ram_addr_a=wcnt, ram_data_a=s_data and ram_wren_a=1, then increment wcnt.
  - Port B is idle; rden_a and rden_b are 0.
  - s_ready drops in the cycle after the FRAME_WORDS-th acceptance, so excess beats are not accepted.
  - The state moves to RUN one cycle after the last write strobe.
- RUN
  - l1_enable=1.
  - ram_addr_a, ram_addr_b, ram_rden_a and ram_rden_b pass straight through from the l1_* inputs.
  - ram_wren_a and ram_wren_b are forced to 0 whatever layer 1 requests.
  - A rising edge of pool_done (registered edge detect) moves the state to IDLE, pulses frame_done and increments frame_count.
- Ignored events:
  - start while busy.
  - pool_done outside RUN.
  - s_valid outside LOAD.
- The edge detector is cleared on entry to RUN, so a pool_done level still high from the previous frame does not end the next frame.
- wcnt is IN_FEATURE_ADDR_WIDTH+1 bits wide, so FRAME_WORDS=2^IN_FEATURE_ADDR_WIDTH ends the load without wrapping.

## Timing
- Reset values: state IDLE; all outputs 0, including frame_count and the registered RAM address and data.
- Reset mid-operation aborts immediately. Partial RAM contents are left undefined. No frame_done pulse is produced.
- Latency:
  - start at cycle t gives s_ready=1 at t+1.
  - A beat accepted at cycle t is written (ram_wren_a=1) at t+1.
  - The last write at cycle w gives l1_enable=1 at w+1.
  - A pool_done rise sampled at cycle p gives frame_done=1 and l1_enable=0 at p+1, with frame_count updated in the same cycle.
- A stall (s_valid=0) holds wcnt; ram_wren_a is 0 in every cycle with no acceptance.
- RUN pass-through is combinational from l1_* to ram_*. All other outputs are registered.

## Structure
- A shared package `in_loader_pkg` holds:
  - the state encoding (IDLE=0, LOAD=1, RUN=2);
  - the frame_count width constant (16);
  - the default FRAME_WORDS.
- One sub-module, `rise_detect`, a registered rising-edge detector with a synchronous clear, used for pool_done.
- The RAM instances stay outside this block.

## Test plan
1. FRAME_WORDS=4, INPUT_NUM_MEM=3, DATA_WIDTH=16, continuous valid beats 0x0001_0002_0003 … 0x000A_000B_000C -> writes to addresses 0..3 with the matching data; l1_enable rises one cycle after the last write.
2. Random s_valid gaps during LOAD -> exactly FRAME_WORDS writes with contiguous addresses and no write strobe in gap cycles; the 5th offered beat sees s_ready=0.
3. In RUN, drive l1_addra=0x155, l1_rden_a=1, l1_wren_a=1 -> ram_addr_a=0x155, ram_rden_a=1, ram_wren_a=0 in the same cycle.
4. pool_done held high for 10 cycles, then a second frame started -> frame_done pulses once and frame_count=1; the second RUN does not end until pool_done falls and rises again; frame_count=2 afterwards.
5. Assert reset at wcnt=2 during LOAD -> all outputs 0 and state IDLE the same cycle. A new start then loads from address 0.
6. start during RUN, and pool_done pulsed in IDLE -> no state change and no frame_done pulse.
